pkt_tx_rcv: RTL and testbench

PKT_TX_RCV -- requirements
Module: pkt_tx_rcv

---
 rtl/pkt_tx_rcv.sv | 186 ++++++++++++++++++
 tb/tb_pkt_tx_rcv.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_tx_rcv.sv
// Packet transmit receive buffer: frames incoming 64-bit words into packets,
// stores them in a circular FIFO and hands them out one word per read request.
module pkt_tx_rcv #(
   parameter int DEPTH       = 16,
   parameter int FULL_THRESH = DEPTH - 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pkt_tx_val,
   input  logic        pkt_tx_sop,
   input  logic        pkt_tx_eop,
   input  logic [2:0]  pkt_tx_mod,
   input  logic [63:0] pkt_tx_data,
   output logic        pkt_tx_full,
   input  logic        rd_ren,
   output logic        rd_avail,
   output logic        rd_val,
   output logic        rd_sop,
   output logic        rd_eop,
   output logic [2:0]  rd_mod,
   output logic [63:0] rd_data,
   output logic        proto_err,
   output logic [15:0] err_cnt,
   output logic [15:0] ovf_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
   localparam logic [AW:0] THRESH  = (AW+1)'(FULL_THRESH);

   typedef enum logic {S_IDLE, S_IN_PKT} state_t;

   state_t        r_state;
   state_t        w_state_next;

   logic [68:0]      r_mem [DEPTH];
   logic [DEPTH-1:0] r_eop_tag;    // eop bit per slot, readable without waiting on the RAM

   logic [AW:0]   r_wptr;
   logic [AW:0]   r_rptr;
   logic [AW:0]   r_pkt_cnt;
   logic          r_tx_full;
   logic          r_rd_val;
   logic          r_rd_sop;
   logic          r_rd_eop;
   logic [2:0]    r_rd_mod;
   logic [63:0]   r_rd_data;
   logic          r_proto_err;
   logic [15:0]   r_err_cnt;
   logic [15:0]   r_ovf_cnt;

   logic          w_fifo_full;
   logic          w_fifo_empty;
   logic          w_store;
   logic          w_err;
   logic          w_ovf;
   logic          w_rd;
   logic          w_eop_in;
   logic          w_eop_out;
   logic [AW:0]   w_wptr_next;
   logic [AW:0]   w_rptr_next;
   logic [AW:0]   w_occ_next;

   assign w_fifo_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign w_fifo_empty = (r_wptr == r_rptr);

   // Emptiness is judged on the current pointers, so a same-cycle write is never read back
   assign w_rd        = rd_ren && !w_fifo_empty;
   assign w_eop_in    = w_store && pkt_tx_eop;
   assign w_eop_out   = w_rd && r_eop_tag[r_rptr[AW-1:0]];
   assign w_wptr_next = w_store ? (r_wptr + PTR_ONE) : r_wptr;
   assign w_rptr_next = w_rd    ? (r_rptr + PTR_ONE) : r_rptr;
   assign w_occ_next  = w_wptr_next - w_rptr_next;

   // Framing FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Framing decisions: store / discard-with-error / overflow drop, and next state
   always_comb begin
      w_state_next = r_state;
      w_store      = 1'b0;
      w_err        = 1'b0;
      w_ovf        = 1'b0;
      if (pkt_tx_val) begin
         if (w_fifo_full) begin
            w_ovf = 1'b1;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (pkt_tx_sop) begin
                     w_store      = 1'b1;
                     w_state_next = pkt_tx_eop ? S_IDLE : S_IN_PKT;
                  end else begin
                     w_err = 1'b1;
                  end
               end
               S_IN_PKT: begin
                  // An unexpected sop restarts the packet but is still kept
                  w_store      = 1'b1;
                  w_err        = pkt_tx_sop;
                  w_state_next = pkt_tx_eop ? S_IDLE : S_IN_PKT;
               end
               default: w_state_next = S_IDLE;
            endcase
         end
      end
   end

   // Word storage; contents are don't-care until written, so no reset
   always_ff @(posedge clk) begin
      if (w_store) begin
         r_mem[r_wptr[AW-1:0]]     <= {pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, pkt_tx_data};
         r_eop_tag[r_wptr[AW-1:0]] <= pkt_tx_eop;
      end
   end

   // Pointers, complete-packet count and registered threshold flag
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_pkt_cnt <= '0;
         r_tx_full <= 1'b0;
      end else begin
         r_wptr    <= w_wptr_next;
         r_rptr    <= w_rptr_next;
         r_tx_full <= (w_occ_next >= THRESH);
         case ({w_eop_in, w_eop_out})
            2'b10:   r_pkt_cnt <= r_pkt_cnt + PTR_ONE;
            2'b01:   r_pkt_cnt <= r_pkt_cnt - PTR_ONE;
            default: r_pkt_cnt <= r_pkt_cnt;
         endcase
      end
   end

   // Read port: one-cycle latency, word fields hold while rd_val is low
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rd_val  <= 1'b0;
         r_rd_sop  <= 1'b0;
         r_rd_eop  <= 1'b0;
         r_rd_mod  <= '0;
         r_rd_data <= '0;
      end else begin
         r_rd_val <= w_rd;
         if (w_rd) begin
            {r_rd_sop, r_rd_eop, r_rd_mod, r_rd_data} <= r_mem[r_rptr[AW-1:0]];
         end
      end
   end

   // Error pulse and saturating error / overflow counters
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_proto_err <= 1'b0;
         r_err_cnt   <= '0;
         r_ovf_cnt   <= '0;
      end else begin
         r_proto_err <= w_err;
         if (w_err && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
         end
         if (w_ovf && (r_ovf_cnt != 16'hFFFF)) begin
            r_ovf_cnt <= r_ovf_cnt + 16'd1;
         end
      end
   end

   assign pkt_tx_full = r_tx_full;
   assign rd_avail    = (r_pkt_cnt != '0);
   assign rd_val      = r_rd_val;
   assign rd_sop      = r_rd_sop;
   assign rd_eop      = r_rd_eop;
   assign rd_mod      = r_rd_mod;
   assign rd_data     = r_rd_data;
   assign proto_err   = r_proto_err;
   assign err_cnt     = r_err_cnt;
   assign ovf_cnt     = r_ovf_cnt;

endmodule

// File: tb/tb_pkt_tx_rcv.sv
// Testbench for pkt_tx_rcv: vector table, directed corner sequences and a
// randomized run checked against a queue-based packet buffer model.
module tb_pkt_tx_rcv;

   localparam int DEPTH       = 16;
   localparam int FULL_THRESH = DEPTH - 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        pkt_tx_val;
   logic        pkt_tx_sop;
   logic        pkt_tx_eop;
   logic [2:0]  pkt_tx_mod;
   logic [63:0] pkt_tx_data;
   logic        pkt_tx_full;
   logic        rd_ren;
   logic        rd_avail;
   logic        rd_val;
   logic        rd_sop;
   logic        rd_eop;
   logic [2:0]  rd_mod;
   logic [63:0] rd_data;
   logic        proto_err;
   logic [15:0] err_cnt;
   logic [15:0] ovf_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pkt_tx_rcv #(.DEPTH(DEPTH), .FULL_THRESH(FULL_THRESH)) dut (
      .clk         (clk),
      .reset       (reset),
      .pkt_tx_val  (pkt_tx_val),
      .pkt_tx_sop  (pkt_tx_sop),
      .pkt_tx_eop  (pkt_tx_eop),
      .pkt_tx_mod  (pkt_tx_mod),
      .pkt_tx_data (pkt_tx_data),
      .pkt_tx_full (pkt_tx_full),
      .rd_ren      (rd_ren),
      .rd_avail    (rd_avail),
      .rd_val      (rd_val),
      .rd_sop      (rd_sop),
      .rd_eop      (rd_eop),
      .rd_mod      (rd_mod),
      .rd_data     (rd_data),
      .proto_err   (proto_err),
      .err_cnt     (err_cnt),
      .ovf_cnt     (ovf_cnt)
   );

   typedef struct {
      logic        val, sop, eop;
      logic [2:0]  mod;
      logic [63:0] data;
      logic        ren;
      logic        x_val, x_sop, x_eop;
      logic [2:0]  x_mod;
      logic [63:0] x_data;
      logic        x_avail, x_perr;
      logic [15:0] x_err;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic val, input logic sop, input logic eop,
                               input logic [2:0] mod, input logic [63:0] data, input logic ren,
                               input logic x_val, input logic x_sop, input logic x_eop,
                               input logic [2:0] x_mod, input logic [63:0] x_data,
                               input logic x_avail, input logic x_perr, input logic [15:0] x_err);
      vec_t v;
      v.val = val; v.sop = sop; v.eop = eop; v.mod = mod; v.data = data; v.ren = ren;
      v.x_val = x_val; v.x_sop = x_sop; v.x_eop = x_eop; v.x_mod = x_mod; v.x_data = x_data;
      v.x_avail = x_avail; v.x_perr = x_perr; v.x_err = x_err;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic val, input logic sop, input logic eop,
                        input logic [2:0] mod, input logic [63:0] data, input logic ren);
      pkt_tx_val  = val;
      pkt_tx_sop  = sop;
      pkt_tx_eop  = eop;
      pkt_tx_mod  = mod;
      pkt_tx_data = data;
      rd_ren      = ren;
   endtask

   task automatic do_reset();
      drive(1'b0, 1'b0, 1'b0, 3'd0, 64'd0, 1'b0);
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // Reference model state
   logic [68:0] m_q[$];
   bit          m_in_pkt;
   int          m_err;
   int          m_ovf;
   logic [68:0] m_rd;
   bit          m_rd_val;
   bit          m_perr;

   function automatic int eop_words();
      int n = 0;
      foreach (m_q[k]) if (m_q[k][67]) n++;
      return n;
   endfunction

   // One clock of the buffer's behaviour, expressed on a packet queue
   task automatic model_step();
      bit full_pre  = (m_q.size() == DEPTH);
      bit empty_pre = (m_q.size() == 0);
      m_rd_val = 0;
      m_perr   = 0;
      if (rd_ren && !empty_pre) begin
         m_rd     = m_q.pop_front();
         m_rd_val = 1;
      end
      if (pkt_tx_val) begin
         if (full_pre) begin
            if (m_ovf < 65535) m_ovf++;
         end else if (!m_in_pkt && !pkt_tx_sop) begin
            m_perr = 1;
            if (m_err < 65535) m_err++;
         end else begin
            if (m_in_pkt && pkt_tx_sop) begin
               m_perr = 1;
               if (m_err < 65535) m_err++;
            end
            m_q.push_back({pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, pkt_tx_data});
            m_in_pkt = !pkt_tx_eop;
         end
      end
   endtask

   initial begin
      vec_t v;
      reset = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 3'd0, 64'd0, 1'b0);
      #3;
      // Reset state
      check("rst_rd_val", rd_val, 1'b0);
      check("rst_rd_data", rd_data, 64'd0);
      check("rst_full", pkt_tx_full, 1'b0);
      check("rst_avail", rd_avail, 1'b0);
      check("rst_perr", proto_err, 1'b0);
      check("rst_err_cnt", err_cnt, 16'd0);
      check("rst_ovf_cnt", ovf_cnt, 16'd0);
      do_reset();

      // ---------------- Vector table ----------------
      tbl.push_back(mk(1,1,0,0,64'hA1,0, 0,0,0,0,64'h0,  0,0,0));
      tbl.push_back(mk(1,0,0,0,64'hA2,0, 0,0,0,0,64'h0,  0,0,0));
      tbl.push_back(mk(1,0,1,5,64'hA3,0, 0,0,0,0,64'h0,  1,0,0));
      tbl.push_back(mk(0,0,0,0,64'h0, 1, 1,1,0,0,64'hA1, 1,0,0));
      tbl.push_back(mk(0,0,0,0,64'h0, 1, 1,0,0,0,64'hA2, 1,0,0));
      tbl.push_back(mk(0,0,0,0,64'h0, 1, 1,0,1,5,64'hA3, 0,0,0));
      tbl.push_back(mk(0,0,0,0,64'h0, 1, 0,0,1,5,64'hA3, 0,0,0));
      tbl.push_back(mk(1,0,0,0,64'hB0,0, 0,0,1,5,64'hA3, 0,1,1));
      tbl.push_back(mk(0,0,0,0,64'h0, 0, 0,0,1,5,64'hA3, 0,0,1));
      tbl.push_back(mk(0,0,0,0,64'h0, 1, 0,0,1,5,64'hA3, 0,0,1));
      tbl.push_back(mk(1,1,0,0,64'hC1,0, 0,0,1,5,64'hA3, 0,0,1));
      tbl.push_back(mk(1,1,0,2,64'hC2,0, 0,0,1,5,64'hA3, 0,1,2));
      tbl.push_back(mk(1,0,1,0,64'hC3,0, 0,0,1,5,64'hA3, 1,0,2));
      tbl.push_back(mk(0,0,0,0,64'h0, 1, 1,1,0,0,64'hC1, 1,0,2));
      tbl.push_back(mk(0,0,0,0,64'h0, 1, 1,1,0,2,64'hC2, 1,0,2));
      tbl.push_back(mk(0,0,0,0,64'h0, 1, 1,0,1,0,64'hC3, 0,0,2));
      tbl.push_back(mk(1,1,1,3,64'hD1,0, 0,0,1,0,64'hC3, 1,0,2));
      tbl.push_back(mk(1,1,1,4,64'hD2,1, 1,1,1,3,64'hD1, 1,0,2));
      tbl.push_back(mk(0,0,0,0,64'h0, 1, 1,1,1,4,64'hD2, 0,0,2));
      tbl.push_back(mk(0,0,1,7,64'hEE,0, 0,1,1,4,64'hD2, 0,0,2));
      tbl.push_back(mk(0,0,0,0,64'h0, 1, 0,1,1,4,64'hD2, 0,0,2));
      tbl.push_back(mk(1,1,1,1,64'h61,1, 0,1,1,4,64'hD2, 1,0,2));
      tbl.push_back(mk(0,0,0,0,64'h0, 1, 1,1,1,1,64'h61, 0,0,2));

      for (int i = 0; i < tbl.size(); i++) begin
         v = tbl[i];
         drive(v.val, v.sop, v.eop, v.mod, v.data, v.ren);
         tick();
         $display("vec %0d: val=%0b sop=%0b eop=%0b ren=%0b -> rd_val=%0b rd_data=%h avail=%0b perr=%0b err=%0d",
                  i, v.val, v.sop, v.eop, v.ren, rd_val, rd_data, rd_avail, proto_err, err_cnt);
         check($sformatf("vec%0d_rd_val", i), rd_val, v.x_val);
         check($sformatf("vec%0d_rd_sop", i), rd_sop, v.x_sop);
         check($sformatf("vec%0d_rd_eop", i), rd_eop, v.x_eop);
         check($sformatf("vec%0d_rd_mod", i), rd_mod, v.x_mod);
         check($sformatf("vec%0d_rd_data", i), rd_data, v.x_data);
         check($sformatf("vec%0d_avail", i), rd_avail, v.x_avail);
         check($sformatf("vec%0d_perr", i), proto_err, v.x_perr);
         check($sformatf("vec%0d_err_cnt", i), err_cnt, v.x_err);
         check($sformatf("vec%0d_full", i), pkt_tx_full, 1'b0);
      end

      // ---------------- Fill to overflow ----------------
      do_reset();
      for (int k = 1; k <= 20; k++) begin
         drive(1'b1, (k == 1), 1'b0, 3'd0, 64'(k), 1'b0);
         tick();
         $display("fill word %0d: full=%0b ovf=%0d", k, pkt_tx_full, ovf_cnt);
         if (k == 11) check("fill_full_at11", pkt_tx_full, 1'b0);
         if (k == 12) check("fill_full_at12", pkt_tx_full, 1'b1);
         if (k == 16) check("fill_ovf_at16", ovf_cnt, 16'd0);
      end
      check("fill_ovf_cnt", ovf_cnt, 16'd4);
      check("fill_avail", rd_avail, 1'b0);
      for (int j = 1; j <= 16; j++) begin
         drive(1'b0, 1'b0, 1'b0, 3'd0, 64'd0, 1'b1);
         tick();
         $display("drain word %0d: rd_val=%0b data=%h full=%0b", j, rd_val, rd_data, pkt_tx_full);
         check($sformatf("drain%0d_data", j), rd_data, 64'(j));
         check($sformatf("drain%0d_sop", j), rd_sop, (j == 1));
         if (j == 4) check("drain_full_at4", pkt_tx_full, 1'b1);
         if (j == 5) check("drain_full_at5", pkt_tx_full, 1'b0);
      end

      // ---------------- Reset mid-packet ----------------
      do_reset();
      drive(1'b1, 1'b0, 1'b0, 3'd0, 64'h99, 1'b0);  tick();
      drive(1'b1, 1'b1, 1'b1, 3'd2, 64'hE1, 1'b0);  tick();
      drive(1'b1, 1'b1, 1'b1, 3'd3, 64'hE2, 1'b0);  tick();
      drive(1'b1, 1'b1, 1'b0, 3'd0, 64'hF1, 1'b0);  tick();
      drive(1'b1, 1'b0, 1'b0, 3'd0, 64'hF2, 1'b1);  tick();
      $display("pre-reset: rd_val=%0b data=%h avail=%0b err=%0d", rd_val, rd_data, rd_avail, err_cnt);
      check("prerst_rd_data", rd_data, 64'hE1);
      check("prerst_avail", rd_avail, 1'b1);
      check("prerst_err_cnt", err_cnt, 16'd1);
      drive(1'b0, 1'b0, 1'b0, 3'd0, 64'd0, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      $display("async reset: rd_val=%0b data=%h avail=%0b err=%0d", rd_val, rd_data, rd_avail, err_cnt);
      check("arst_rd_val", rd_val, 1'b0);
      check("arst_rd_sop", rd_sop, 1'b0);
      check("arst_rd_eop", rd_eop, 1'b0);
      check("arst_rd_mod", rd_mod, 3'd0);
      check("arst_rd_data", rd_data, 64'd0);
      check("arst_avail", rd_avail, 1'b0);
      check("arst_full", pkt_tx_full, 1'b0);
      check("arst_err_cnt", err_cnt, 16'd0);
      tick();
      reset = 1'b0;
      drive(1'b1, 1'b1, 1'b1, 3'd6, 64'h7777, 1'b0);  tick();
      check("post_perr", proto_err, 1'b0);
      check("post_avail", rd_avail, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 3'd0, 64'd0, 1'b1);     tick();
      $display("post-reset read: rd_val=%0b data=%h sop=%0b eop=%0b mod=%0d err=%0d",
               rd_val, rd_data, rd_sop, rd_eop, rd_mod, err_cnt);
      check("post_rd_val", rd_val, 1'b1);
      check("post_rd_data", rd_data, 64'h7777);
      check("post_rd_sop", rd_sop, 1'b1);
      check("post_rd_eop", rd_eop, 1'b1);
      check("post_rd_mod", rd_mod, 3'd6);
      check("post_err_cnt", err_cnt, 16'd0);
      check("post_avail_after", rd_avail, 1'b0);

      // ---------------- Randomized run against the model ----------------
      do_reset();
      m_q.delete();
      m_in_pkt = 0;
      m_err    = 0;
      m_ovf    = 0;
      m_rd     = '0;
      for (int blk = 0; blk < 8; blk++) begin
         int wp = $urandom_range(30, 100);
         int rp = $urandom_range(5, 90);
         for (int c = 0; c < 250; c++) begin
            drive(($urandom_range(0, 99) < wp), ($urandom_range(0, 99) < 30),
                  ($urandom_range(0, 99) < 30), 3'($urandom_range(0, 7)),
                  {$urandom, $urandom}, ($urandom_range(0, 99) < rp));
            model_step();
            tick();
            if (rd_val)
               $display("rand blk %0d cyc %0d: read sop=%0b eop=%0b mod=%0d data=%h",
                        blk, c, rd_sop, rd_eop, rd_mod, rd_data);
            check("rand_rd_val", rd_val, m_rd_val);
            check("rand_rd_sop", rd_sop, m_rd[68]);
            check("rand_rd_eop", rd_eop, m_rd[67]);
            check("rand_rd_mod", rd_mod, m_rd[66:64]);
            check("rand_rd_data", rd_data, m_rd[63:0]);
            check("rand_avail", rd_avail, (eop_words() != 0));
            check("rand_full", pkt_tx_full, (m_q.size() >= FULL_THRESH));
            check("rand_perr", proto_err, m_perr);
            check("rand_err_cnt", err_cnt, 16'(m_err));
            check("rand_ovf_cnt", ovf_cnt, 16'(m_ovf));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
